fpga2usb_bridge: RTL

Parametrised successor to the switch-to-LED/USB mirror. It takes WIDTH raw switch inputs, synchronises and debounces each bit, and drives the debounced value onto the LEDs, with an optional freeze. Each new value is delivered to the USB pins through a valid/ack handshake, so the host never samples a changing bus. It sits between the board switch bank and the USB interface header.

---
 rtl/fpga2usb_pkg.sv | 21 ++
 rtl/fpga2usb_bridge_debounce.sv | 58 +++++
 rtl/fpga2usb_bridge.sv | 95 +++++++++
 3 files changed

// File: rtl/fpga2usb_pkg.sv
// Shared types and defaults for the switch-to-LED/USB bridge.
// Holds the USB handshake state encoding, default parameter values,
// the coalesce counter width and its saturating-increment helper.
package fpga2usb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam int DEF_WIDTH           = 6;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int COALESCE_W          = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COALESCE_W-1:0] sat_inc(input logic [COALESCE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fpga2usb_bridge_debounce.sv
// Single-bit synchroniser plus debouncer for one switch line.
// Latency: SYNC_STAGES edges through the chain, then DEBOUNCE_CYCLES edges to accept.
// No backpressure; accept_o pulses on the edge where stable_o is about to change.
// Ports: clk/reset, raw_i (async switch), stable_o (debounced bit),
//        accept_o (combinational: stable_o updates on the coming edge).
module switch_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic accept_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Counter measures how long the synchronised bit has disagreed with the
  // accepted value; any agreement restarts it, so short glitches die here.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    accept_o = 1'b0;
    if (sync_bit == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync_bit;
      cnt_d    = '0;
      accept_o = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/fpga2usb_bridge.sv
// Debounces a switch bank onto LEDs and hands each new value to USB via valid/ack.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES edges to stable, +1 edge to led/usb_valid.
// Backpressure: usb holds while usb_valid=1; changes during a transfer are coalesced.
// Ports: clk/reset; switch (raw), hold (freeze led, block launches); led;
//        usb/usb_valid/usb_ack handshake; coalesce_cnt (saturating).
module fpga2usb_bridge
  import fpga2usb_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      switch,
  input  logic                  hold,
  output logic [WIDTH-1:0]      led,
  output logic [WIDTH-1:0]      usb,
  output logic                  usb_valid,
  input  logic                  usb_ack,
  output logic [COALESCE_W-1:0] coalesce_cnt
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (switch[i]),
      .stable_o (stable[i]),
      .accept_o (accept[i])
    );
  end

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      led_q, led_d;
  logic [WIDTH-1:0]      usb_q, usb_d;
  logic [WIDTH-1:0]      last_sent_q, last_sent_d;
  logic [COALESCE_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      led_q       <= '0;
      usb_q       <= '0;
      last_sent_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      led_q       <= led_d;
      usb_q       <= usb_d;
      last_sent_q <= last_sent_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    led_d       = hold ? led_q : stable;
    usb_d       = usb_q;
    last_sent_d = last_sent_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!hold && (stable != last_sent_q)) begin
          usb_d   = stable;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // accept is the edge-of-change of stable, so a change landing on the
        // ack edge is still counted; IDLE then picks up the newest value.
        if (|accept) begin
          cnt_d = sat_inc(cnt_q);
        end
        if (usb_ack) begin
          last_sent_d = usb_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign led          = led_q;
  assign usb          = usb_q;
  assign usb_valid    = (state_q == ST_SEND);
  assign coalesce_cnt = cnt_q;

endmodule
